// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the text overlay path.
//   CHAR_SPACE / CHAR_DIGIT0 : character codes used by the text writer
//   text_op_t                : command op codes for menu_text_writer
//   text_state_t             : menu_text_writer FSM states
package vga_pkg;

  localparam logic [6:0] CHAR_SPACE  = 7'h20;
  localparam logic [6:0] CHAR_DIGIT0 = 7'h30;

  typedef enum logic [1:0] {
    OP_CHAR  = 2'd0,
    OP_NUM   = 2'd1,
    OP_CLEAR = 2'd2,
    OP_NOP   = 2'd3
  } text_op_t;

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    IDLE    = 3'd1,
    WR_CHAR = 3'd2,
    CONV    = 3'd3,
    EMIT    = 3'd4
  } text_state_t;

endpackage

// File: rtl/text_ram.sv
// text_ram: 256x7 simple dual-port character RAM.
//   clk, rst : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata : write port
//   raddr, rdata     : registered read port, read-before-write on collision
module text_ram
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [6:0] wdata,
  input  logic [7:0] raddr,
  output logic [6:0] rdata
);

  logic [6:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register reset only; the array itself is initialised by the
  // writer's clear sweep.
  always_ff @(posedge clk) begin
    if (rst) rdata <= CHAR_SPACE;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/menu_text_writer.sv
// menu_text_writer: writable 16x16 character buffer for menu/HUD text.
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid / cmd_ready    : command handshake (accept on valid && ready)
//   cmd_op, cmd_xy, cmd_char,
//   cmd_num, cmd_blank_lz    : command fields, captured on accept
//   busy                     : ~cmd_ready
//   char_xy / char_code      : renderer read port, 1-cycle latency
//
// state   | meaning
// CLEAR   | writing SPACE to every cell, one per cycle (also after reset)
// IDLE    | ready for a command
// WR_CHAR | writing the captured character
// CONV    | double-dabble binary to BCD, one shift per cycle
// EMIT    | writing one decimal digit per cycle, MSD first
module menu_text_writer
  import vga_pkg::*;
#(
  parameter int NUM_DIGITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_xy,
  input  logic [6:0]  cmd_char,
  input  logic [15:0] cmd_num,
  input  logic        cmd_blank_lz,
  output logic        busy,
  input  logic [7:0]  char_xy,
  output logic [6:0]  char_code
);

  localparam int BCD_W = 4 * NUM_DIGITS;

  text_state_t       state_q, state_d;
  logic [7:0]        addr_q;
  logic [3:0]        cnt_q;
  logic [7:0]        xy_q;
  logic [6:0]        char_q;
  logic              blank_q;
  logic [15:0]       bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [3:0]        digit;
  logic              we;
  logic [7:0]        waddr;
  logic [6:0]        wdata;

  always_ff @(posedge clk) begin
    if (rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    we        = 1'b0;
    waddr     = addr_q;
    wdata     = CHAR_SPACE;
    digit     = bcd_q[BCD_W-1 -: 4];
    bcd_adj   = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      CLEAR: begin
        we = 1'b1;
        if (addr_q == 8'hFF) state_d = IDLE;
      end
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (text_op_t'(cmd_op))
            OP_CHAR:  state_d = WR_CHAR;
            OP_NUM:   state_d = CONV;
            OP_CLEAR: state_d = CLEAR;
            default:  state_d = IDLE;
          endcase
        end
      end
      WR_CHAR: begin
        we      = 1'b1;
        waddr   = xy_q;
        wdata   = char_q;
        state_d = IDLE;
      end
      CONV: begin
        if (cnt_q == 4'd0) state_d = EMIT;
      end
      EMIT: begin
        we = 1'b1;
        // cnt_q == 0 is the last digit, which is never blanked
        if (blank_q && digit == 4'd0 && cnt_q != 4'd0) wdata = CHAR_SPACE;
        else                                           wdata = CHAR_DIGIT0 + {3'b000, digit};
        if (cnt_q == 4'd0) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 8'h00;
      cnt_q   <= 4'd0;
      xy_q    <= 8'h00;
      char_q  <= CHAR_SPACE;
      blank_q <= 1'b0;
      bin_q   <= 16'h0000;
      bcd_q   <= '0;
    end else begin
      case (state_q)
        CLEAR: addr_q <= addr_q + 8'd1;
        IDLE: begin
          if (cmd_valid) begin
            xy_q    <= cmd_xy;
            char_q  <= cmd_char;
            blank_q <= cmd_blank_lz;
            bin_q   <= cmd_num;
            bcd_q   <= '0;
            cnt_q   <= 4'd15;
            addr_q  <= 8'h00;
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            cnt_q  <= 4'(NUM_DIGITS - 1);
            addr_q <= xy_q;
          end
        end
        EMIT: begin
          addr_q <= addr_q + 8'd1;
          bcd_q  <= {bcd_q[BCD_W-5:0], 4'h0};
          cnt_q  <= cnt_q - 4'd1;
          if (digit != 4'd0) blank_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = ~cmd_ready;

  text_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (char_xy),
    .rdata (char_code)
  );

endmodule

// File: tb/tb_menu_text_writer.sv
// tb_menu_text_writer: self-checking bench for menu_text_writer with a
// character-array reference model of the screen.
module tb_menu_text_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd3;
  logic [7:0]  cmd_xy = 8'h00;
  logic [6:0]  cmd_char = 7'h00;
  logic [15:0] cmd_num = 16'h0000;
  logic        cmd_blank_lz = 1'b0;
  logic        busy;
  logic [7:0]  char_xy = 8'h00;
  logic [6:0]  char_code;

  int checks = 0;
  int failures = 0;

  logic [6:0] model [256];

  always #5 clk = ~clk;

  menu_text_writer #(.NUM_DIGITS(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_xy       (cmd_xy),
    .cmd_char     (cmd_char),
    .cmd_num      (cmd_num),
    .cmd_blank_lz (cmd_blank_lz),
    .busy         (busy),
    .char_xy      (char_xy),
    .char_code    (char_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input logic [7:0] a, output logic [6:0] v);
    char_xy = a;
    tick();
    v = char_code;
  endtask

  // Screen effect of one command, from the command definitions alone.
  function automatic void model_apply(input logic [1:0] op, input logic [7:0] xy,
                                      input logic [6:0] ch, input logic [15:0] num,
                                      input logic blank);
    int div;
    int d;
    bit seen;
    logic [7:0] a;
    case (op)
      2'd0: model[xy] = ch;
      2'd1: begin
        div  = 10000;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
          d = (int'(num) / div) % 10;
          a = xy + 8'(i);
          if (blank && !seen && d == 0 && i < 4) model[a] = 7'h20;
          else begin
            model[a] = 7'h30 + 7'(d);
            seen = 1'b1;
          end
          div = div / 10;
        end
      end
      2'd2: for (int i = 0; i < 256; i++) model[i] = 7'h20;
      default: ;
    endcase
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 2000) begin
      tick();
      w++;
    end
    if (!cmd_ready) begin
      $display("FAIL wait_ready cmd_ready=%0b required=1", cmd_ready);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "ready timeout");
    end
  endtask

  // Issue one command and return how many cycles cmd_ready stayed low.
  task automatic send(input logic [1:0] op, input logic [7:0] xy, input logic [6:0] ch,
                      input logic [15:0] num, input logic blank, output int busy_cyc);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_xy = xy; cmd_char = ch;
    cmd_num = num; cmd_blank_lz = blank;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd3;
    model_apply(op, xy, ch, num, blank);
    busy_cyc = 0;
    while (!cmd_ready && busy_cyc < 400) begin
      tick();
      busy_cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic [6:0] v;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", cmd_ready); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%0b exp=1", busy); end
    checks++;
    if (char_code !== 7'h20) begin failures++; $display("FAIL reset_char_code got=%h exp=20", char_code); end
    rst = 1'b0;
    cyc = 0;
    while (!cmd_ready && cyc < 1000) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 256) begin failures++; $display("FAIL reset_clear_cycles got=%0d exp=256", cyc); end
    for (int i = 0; i < 256; i++) model[i] = 7'h20;
    for (int i = 0; i < 256; i++) begin
      read_cell(8'(i), v);
      checks++;
      if (v !== model[i]) begin failures++; $display("FAIL reset_sweep addr=%h got=%h exp=%h", i, v, model[i]); end
    end
  endtask

  task automatic test_char();
    int b;
    logic [6:0] v;
    logic [7:0] a;
    logic [7:0] written [$];
    send(2'd0, 8'h23, 7'h4D, 16'h0, 1'b0, b);
    checks++;
    if (b != 1) begin failures++; $display("FAIL char_busy got=%0d exp=1", b); end
    for (int i = 0; i < 3; i++) begin
      a = 8'h22 + 8'(i);
      read_cell(a, v);
      checks++;
      if (v !== model[a]) begin failures++; $display("FAIL char_cell addr=%h got=%h exp=%h", a, v, model[a]); end
    end
    for (int k = 0; k < 10; k++) begin
      a = 8'($urandom_range(0, 255));
      send(2'd0, a, 7'($urandom_range(33, 126)), 16'h0, 1'b0, b);
      written.push_back(a);
      checks++;
      if (b != 1) begin failures++; $display("FAIL char_rand_busy got=%0d exp=1", b); end
    end
    foreach (written[k]) begin
      read_cell(written[k], v);
      checks++;
      if (v !== model[written[k]]) begin
        failures++; $display("FAIL char_rand_cell addr=%h got=%h exp=%h", written[k], v, model[written[k]]);
      end
    end
  endtask

  task automatic test_num();
    int b;
    logic [6:0] v;
    logic [7:0] a;
    logic [7:0]  xs [10];
    logic [15:0] ns [10];
    logic        bl [10];
    xs[0] = 8'h40; ns[0] = 16'd12345; bl[0] = 1'b0;
    xs[1] = 8'hFE; ns[1] = 16'd42;    bl[1] = 1'b1;
    xs[2] = 8'h60; ns[2] = 16'd0;     bl[2] = 1'b1;
    xs[3] = 8'h70; ns[3] = 16'd65535; bl[3] = 1'b0;
    xs[4] = 8'h90; ns[4] = 16'd0;     bl[4] = 1'b0;
    for (int k = 5; k < 10; k++) begin
      xs[k] = 8'($urandom_range(0, 255));
      ns[k] = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      bl[k] = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < 10; k++) begin
      send(2'd1, xs[k], 7'h00, ns[k], bl[k], b);
      checks++;
      if (b != 21) begin failures++; $display("FAIL num_busy case=%0d got=%0d exp=21", k, b); end
      for (int i = -1; i < 6; i++) begin
        a = xs[k] + 8'(i);
        read_cell(a, v);
        checks++;
        if (v !== model[a]) begin
          failures++; $display("FAIL num_cell case=%0d num=%0d addr=%h got=%h exp=%h", k, ns[k], a, v, model[a]);
        end
      end
    end
  endtask

  task automatic test_handshake();
    int cyc;
    int b;
    logic [6:0] v;
    logic [7:0] a;
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_xy = 8'h80; cmd_num = 16'd9876; cmd_blank_lz = 1'b0;
    tick();
    model_apply(2'd1, 8'h80, 7'h00, 16'd9876, 1'b0);
    cmd_op = 2'd0; cmd_xy = 8'h82; cmd_char = 7'h5A; cmd_num = 16'd1; cmd_blank_lz = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 21) begin failures++; $display("FAIL hs_num_busy got=%0d exp=21", cyc); end
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd3;
    model_apply(2'd0, 8'h82, 7'h5A, 16'd0, 1'b0);
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL hs_second_accept ready=%0b exp=0", cmd_ready); end
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL hs_second_done ready=%0b exp=1", cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      a = 8'h80 + 8'(i);
      read_cell(a, v);
      checks++;
      if (v !== model[a]) begin failures++; $display("FAIL hs_cell addr=%h got=%h exp=%h", a, v, model[a]); end
    end
    send(2'd3, 8'h80, 7'h41, 16'd5, 1'b0, b);
    checks++;
    if (b != 0) begin failures++; $display("FAIL nop_busy got=%0d exp=0", b); end
    send(2'd0, 8'h10, 7'h51, 16'd0, 1'b0, b);
    checks++;
    if (b != 1) begin failures++; $display("FAIL nop_b2b_busy got=%0d exp=1", b); end
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 8'h80 : 8'h10;
      read_cell(a, v);
      checks++;
      if (v !== model[a]) begin failures++; $display("FAIL nop_cell addr=%h got=%h exp=%h", a, v, model[a]); end
    end
  endtask

  task automatic test_clear_cmd();
    int b;
    logic [6:0] v;
    send(2'd2, 8'h00, 7'h00, 16'h0, 1'b0, b);
    checks++;
    if (b != 256) begin failures++; $display("FAIL clear_busy got=%0d exp=256", b); end
    for (int i = 0; i < 256; i++) begin
      read_cell(8'(i), v);
      checks++;
      if (v !== model[i]) begin failures++; $display("FAIL clear_sweep addr=%h got=%h exp=%h", i, v, model[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int b;
    int cyc;
    logic [6:0] v;
    for (int i = 0; i < 16; i++) begin
      send(2'd0, 8'hC0 + 8'(i), 7'h41, 16'h0, 1'b0, b);
    end
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'd2;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd3;
    repeat (100) tick();
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_clear_ready got=%0b exp=0", cmd_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 7'h20;
    cyc = 0;
    while (!cmd_ready && cyc < 1000) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 256) begin failures++; $display("FAIL mid_reset_cycles got=%0d exp=256", cyc); end
    for (int i = 0; i < 256; i++) begin
      read_cell(8'(i), v);
      checks++;
      if (v !== model[i]) begin failures++; $display("FAIL mid_reset_sweep addr=%h got=%h exp=%h", i, v, model[i]); end
    end
  endtask

  task automatic test_collision();
    logic [6:0] old_v;
    logic [6:0] new_v;
    wait_ready();
    old_v = model[8'h37];
    new_v = (old_v == 7'h7E) ? 7'h7D : 7'h7E;
    char_xy = 8'h37;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_xy = 8'h37; cmd_char = new_v;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd3;
    model_apply(2'd0, 8'h37, new_v, 16'h0, 1'b0);
    tick();
    checks++;
    if (char_code !== old_v) begin failures++; $display("FAIL collide_old got=%h exp=%h", char_code, old_v); end
    tick();
    checks++;
    if (char_code !== model[8'h37]) begin failures++; $display("FAIL collide_new got=%h exp=%h", char_code, model[8'h37]); end
  endtask

  initial begin
    test_reset();
    test_char();
    test_num();
    test_handshake();
    test_collision();
    test_clear_cmd();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
